feistel_round_engine: RTL and testbench
=======================================

// Module: feistel_round_engine
// PURPOSE
//   Iterative DES Feistel core. Consumes the L/R 32-bit halves produced by the
//   64-bit block splitter and runs ROUNDS rounds, one round per clock. The
//   f-function (expansion, key XOR, S-boxes, P) is an external combinational
//   block driven through the f_* ports. Output is the pre-output block R16||L16,
//   ready for the final permutation stage.
// PARAMETERS
//   W       32  width of one half-block (L or R)
//   ROUNDS  16  Feistel rounds per block; must be >=2; round index width = clog2(ROUNDS)
// PORTS
//   clk        in   1    rising-edge clock
//   rst        in   1    asynchronous, active-high reset
//   in_valid   in   1    L_in/R_in/decrypt valid
//   in_ready   out  1    engine can accept a block
//   L_in       in   W    left half from splitter (in[63:32])
//   R_in       in   W    right half from splitter (in[31:0])
//   decrypt    in   1    0 = encrypt key order, 1 = decrypt key order; sampled on accept
//   f_R        out  W    current R, the data input of the external f-function
//   f_round    out  4    subkey index for the key schedule (0..ROUNDS-1)
//   f_out      in   W    f(f_R, K[f_round]), combinational, same cycle
//   out_valid  out  1    out holds a finished block
//   out_ready  in   1    downstream accepts out
//   out        out  2W   pre-output {R_final, L_final}
//   busy       out  1    high in RUN or DONE
// BEHAVIOUR
//   Reset: state=IDLE, L/R regs=0, round=0, dec=0; in_ready=1, out_valid=0,
//     busy=0, out=0, f_R=0, f_round=0.
//   FSM states IDLE, RUN, DONE:
//   - IDLE: in_ready=1. in_valid&in_ready at edge -> L<=L_in, R<=R_in, round<=0,
//     dec<=decrypt, go RUN. No computation happens in the accept cycle.
//   - RUN: each edge: L<=R; R<=L^f_out; round<=round+1.
//     On the edge where round==ROUNDS-1 the last update is taken -> DONE.
//   - DONE: out_valid=1, out={R,L} (final swap undone). Held stable while
//     out_ready=0. out_valid&out_ready at edge -> IDLE. No same-cycle re-accept.
//   f_R = R reg at all times. f_round = round when dec=0, ROUNDS-1-round when dec=1.
//   in_ready=0 in RUN and DONE; in_valid then ignored (no buffering).
//   Latency: accept edge at cycle 0 -> out_valid high after edge ROUNDS
//     (ROUNDS+1 cycles accept-to-output). Throughput: 1 block per ROUNDS+2 cycles
//     with out_ready held high.
//   Round counter never wraps: it stops advancing outside RUN and is cleared on accept.
//   L/R/round hold their values in DONE; f_out is ignored outside RUN.
//   Reset asserted mid-RUN or in DONE: abort immediately, all state returns to
//     reset values, the partial block is discarded, and no out_valid pulse occurs.
//   All arithmetic is bitwise XOR on W bits; no carries, no width growth.
// TESTING
//   1 Known DES vector: L_in=CC00CCFF R_in=F0AAF0AA, decrypt=0, real f/key schedule
//     for key 133457799BBCDFF1 -> out=0A4CD99543423234 after 17 cycles.
//   2 Stub f_out=0, L_in=11111111 R_in=22222222 -> out=2222222211111111;
//     f_R alternates 22222222/11111111 each RUN cycle.
//   3 decrypt=1: f_round sequence 15,14,...,0 over RUN; decrypt=0: 0..15. Feed
//     vector 1's out (halves swapped) through decrypt -> original L/R recovered.
//   4 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid stays 1, out
//     stable, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
//   5 in_valid pulsed during RUN with a different block -> ignored, result unchanged.
//   6 rst asserted at round 7 -> same cycle out_valid=0, busy=0, in_ready=1;
//     a new block afterwards completes correctly.

Source files
------------

// File: rtl/feistel_round_engine.sv
// Iterative Feistel round engine: one round per clock, with the f-function supplied
// externally through the f_* ports. Produces the pre-output block {R_final, L_final}.
module feistel_round_engine #(
  parameter int W      = 32,
  parameter int ROUNDS = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   L_in,
  input  logic [W-1:0]   R_in,
  input  logic           decrypt,
  output logic [W-1:0]   f_R,
  output logic [3:0]     f_round,
  input  logic [W-1:0]   f_out,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out,
  output logic           busy
);

  localparam int            RW   = $clog2(ROUNDS);
  localparam logic [RW-1:0] LAST = RW'(ROUNDS - 1);

  // state  | meaning
  // S_IDLE | waiting for a block, in_ready high
  // S_RUN  | one Feistel round per clock, f_out consumed
  // S_DONE | result presented on out until out_ready
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state;
  logic [W-1:0]  r_L;
  logic [W-1:0]  r_R;
  logic [RW-1:0] r_round;
  logic          r_dec;
  logic          r_in_ready;
  logic          r_out_valid;
  logic          r_busy;
  logic [RW-1:0] w_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_L         <= '0;
      r_R         <= '0;
      r_round     <= '0;
      r_dec       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_L        <= L_in;
            r_R        <= R_in;
            r_round    <= '0;
            r_dec      <= decrypt;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_L <= r_R;
          r_R <= r_L ^ f_out;
          // The counter parks on the last index so it can never wrap.
          if (r_round == LAST) begin
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_round <= r_round + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_idx     = r_dec ? (LAST - r_round) : r_round;
  assign f_round   = 4'(w_idx);
  assign f_R       = r_R;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  // Final swap is undone by presenting R before L.
  assign out       = r_out_valid ? {r_R, r_L} : '0;

endmodule

// File: tb/tb_feistel_round_engine.sv
// Bench for feistel_round_engine: acts as the external DES f-function and key schedule,
// and compares finished blocks against a queue of expected results.
module tb_feistel_round_engine;

  localparam int W      = 32;
  localparam int ROUNDS = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  L_in = '0;
  logic [W-1:0]  R_in = '0;
  logic          decrypt = 1'b0;
  logic [W-1:0]  f_R;
  logic [3:0]    f_round;
  logic [W-1:0]  f_out;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [2*W-1:0] out;
  logic          busy;

  int errs   = 0;
  int checks = 0;
  logic [63:0] sb[$];
  logic        f_mode = 1'b0;
  logic [47:0] subkey [16];

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;

  int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                   16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                   2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                     19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                     14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                     41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  int SH_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  int SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s;
    logic [31:0] p;
    logic [5:0]  b;
    int          row;
    int          col;
    for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
    e = e ^ k;
    for (int j = 0; j < 8; j++) begin
      b   = e[47-6*j -: 6];
      row = int'({b[5], b[0]});
      col = int'(b[4:1]);
      s[31-4*j -: 4] = 4'(SBOX[j][row*16+col]);
    end
    for (int i = 0; i < 32; i++) p[31-i] = s[32-P_T[i]];
    return p;
  endfunction

  // Straight-line reference: 16 rounds then the swapped {R, L} pre-output.
  function automatic logic [63:0] ref_blk(input logic [31:0] l, input logic [31:0] r,
                                          input logic dec, input logic des);
    logic [31:0] t;
    logic [31:0] nl;
    int          k;
    for (int i = 0; i < 16; i++) begin
      k  = dec ? 15 - i : i;
      t  = des ? des_f(r, subkey[k]) : 32'h0;
      nl = r;
      r  = l ^ t;
      l  = nl;
    end
    return {r, l};
  endfunction

  assign f_out = f_mode ? des_f(f_R, subkey[f_round]) : 32'h0;

  always #5 clk = ~clk;

  feistel_round_engine #(.W(W), .ROUNDS(ROUNDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .L_in      (L_in),
    .R_in      (R_in),
    .decrypt   (decrypt),
    .f_R       (f_R),
    .f_round   (f_round),
    .f_out     (f_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_state(input string tag);
    chk({tag, "_in_ready"},  64'(in_ready), 64'd1);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_busy"},      64'(busy), 64'd0);
    chk({tag, "_out"},       out, 64'd0);
    chk({tag, "_f_R"},       64'(f_R), 64'd0);
    chk({tag, "_f_round"},   64'(f_round), 64'd0);
  endtask

  task automatic run_block(input logic [31:0] l, input logic [31:0] r, input logic dec,
                           input logic des, input logic [63:0] exp_v, input logic bp,
                           input logic inj, input int abort_at);
    logic [63:0] e;
    int          k;
    f_mode = des;
    k = 0;
    while (!in_ready && k < 40) begin
      tick();
      k++;
    end
    chk("wait_in_ready", 64'(in_ready), 64'd1);
    out_ready = !bp;
    L_in      = l;
    R_in      = r;
    decrypt   = dec;
    in_valid  = 1'b1;
    sb.push_back(exp_v);
    tick();
    in_valid = 1'b0;
    chk("run_busy", 64'(busy), 64'd1);
    chk("run_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < ROUNDS; i++) begin
      if (i == abort_at) begin
        rst = 1'b1;
        #1;
        check_idle_state("abort");
        void'(sb.pop_back());
        tick();
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
          chk("abort_no_valid", 64'(out_valid), 64'd0);
          tick();
        end
        return;
      end
      chk("f_round", 64'(f_round), 64'(dec ? 15 - i : i));
      if (!des) chk("f_R_alt", 64'(f_R), 64'((i % 2 == 0) ? r : l));
      chk("run_out_valid", 64'(out_valid), 64'd0);
      if (inj && i == 5) begin
        in_valid = 1'b1;
        L_in     = ~l;
        R_in     = ~r;
        decrypt  = ~dec;
      end
      if (inj && i == 9) in_valid = 1'b0;
      tick();
    end
    chk("done_out_valid", 64'(out_valid), 64'd1);
    if (sb.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    if (bp) begin
      for (int c = 0; c < 5; c++) begin
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_out", out, e);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_busy", 64'(busy), 64'd1);
        tick();
      end
      out_ready = 1'b1;
    end
    chk("out", out, e);
    tick();
    chk("post_in_ready", 64'(in_ready), 64'd1);
    chk("post_out_valid", 64'(out_valid), 64'd0);
    chk("post_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [55:0] cd;
    logic [27:0] c;
    logic [27:0] d;
    logic [55:0] cdr;
    logic [31:0] rl;
    logic [31:0] rr;
    logic        rd;

    for (int i = 0; i < 56; i++) cd[55-i] = KEY[64-PC1_T[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int n = 0; n < 16; n++) begin
      for (int s = 0; s < SH_T[n]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cdr = {c, d};
      for (int i = 0; i < 48; i++) subkey[n][47-i] = cdr[56-PC2_T[i]];
    end

    repeat (3) @(posedge clk);
    #1;
    check_idle_state("rst_held");
    rst = 1'b0;
    tick();
    check_idle_state("rst_rel");

    // Known DES vector, encrypt
    run_block(32'hCC00CCFF, 32'hF0AAF0AA, 1'b0, 1'b1, 64'h0A4CD99543423234, 1'b0, 1'b0, -1);
    // Zero f-function: halves just swap every round
    run_block(32'h11111111, 32'h22222222, 1'b0, 1'b0, 64'h2222222211111111, 1'b0, 1'b0, -1);
    // Decrypt the pre-output back to the original halves
    run_block(32'h0A4CD995, 32'h43423234, 1'b1, 1'b1, 64'hCC00CCFFF0AAF0AA, 1'b0, 1'b0, -1);
    // Backpressure in DONE
    run_block(32'hDEADBEEF, 32'h01234567, 1'b0, 1'b1,
              ref_blk(32'hDEADBEEF, 32'h01234567, 1'b0, 1'b1), 1'b1, 1'b0, -1);
    // in_valid pulsed mid-run with another block
    run_block(32'hCC00CCFF, 32'hF0AAF0AA, 1'b0, 1'b1, 64'h0A4CD99543423234, 1'b0, 1'b1, -1);
    // Reset at round 7, then a fresh block
    run_block(32'h89ABCDEF, 32'h76543210, 1'b0, 1'b1, 64'h0, 1'b0, 1'b0, 7);
    check_idle_state("after_abort");
    run_block(32'h89ABCDEF, 32'h76543210, 1'b1, 1'b1,
              ref_blk(32'h89ABCDEF, 32'h76543210, 1'b1, 1'b1), 1'b0, 1'b0, -1);

    for (int n = 0; n < 3; n++) begin
      rl = $urandom;
      rr = $urandom;
      rd = 1'($urandom_range(0, 1));
      run_block(rl, rr, rd, 1'b1, ref_blk(rl, rr, rd, 1'b1), 1'b0, 1'b0, -1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
